// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: state encodings, error codes and the
// ID-stage opcode constants reused by the optional opcode check.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      LDR_ST_IDLE  = 3'd0,
      LDR_ST_LOAD  = 3'd1,
      LDR_ST_WRITE = 3'd2,
      LDR_ST_DONE  = 3'd3,
      LDR_ST_ERROR = 3'd4
   } ldr_state_e;

   localparam logic [1:0] LDR_ERR_NONE     = 2'd0;
   localparam logic [1:0] LDR_ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] LDR_ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] LDR_ERR_BAD_OP   = 2'd3;

   localparam logic [5:0] OPCODE_RTYPE = 6'd0;
   localparam logic [5:0] OPCODE_J     = 6'd2;
   localparam logic [5:0] OPCODE_JAL   = 6'd3;
   localparam logic [5:0] OPCODE_BEQ   = 6'd4;
   localparam logic [5:0] OPCODE_BNE   = 6'd5;
   localparam logic [5:0] OPCODE_ADDI  = 6'd8;
   localparam logic [5:0] OPCODE_ADDIU = 6'd9;
   localparam logic [5:0] OPCODE_SLTI  = 6'd10;
   localparam logic [5:0] OPCODE_SLTIU = 6'd11;
   localparam logic [5:0] OPCODE_ANDI  = 6'd12;
   localparam logic [5:0] OPCODE_ORI   = 6'd13;
   localparam logic [5:0] OPCODE_XORI  = 6'd14;
   localparam logic [5:0] OPCODE_LUI   = 6'd15;
   localparam logic [5:0] OPCODE_LB    = 6'd32;
   localparam logic [5:0] OPCODE_LH    = 6'd33;
   localparam logic [5:0] OPCODE_LW    = 6'd35;
   localparam logic [5:0] OPCODE_LBU   = 6'd36;
   localparam logic [5:0] OPCODE_LHU   = 6'd37;
   localparam logic [5:0] OPCODE_LWU   = 6'd39;
   localparam logic [5:0] OPCODE_SB    = 6'd40;
   localparam logic [5:0] OPCODE_SH    = 6'd41;
   localparam logic [5:0] OPCODE_SW    = 6'd43;

endpackage

// File: rtl/instr_loader_opcheck.sv
// Combinational check: is this opcode one the ID-stage control decoder implements?
module instr_loader_opcheck
   import instr_loader_pkg::*;
(
   input  logic [5:0] opcode_i,
   output logic       supported_o
);

   always_comb begin
      supported_o = 1'b0;
      case (opcode_i)
         OPCODE_RTYPE, OPCODE_J, OPCODE_JAL, OPCODE_BEQ, OPCODE_BNE,
         OPCODE_ADDI, OPCODE_ADDIU, OPCODE_SLTI, OPCODE_SLTIU,
         OPCODE_ANDI, OPCODE_ORI, OPCODE_XORI, OPCODE_LUI,
         OPCODE_LB, OPCODE_LH, OPCODE_LW, OPCODE_LBU, OPCODE_LHU, OPCODE_LWU,
         OPCODE_SB, OPCODE_SH, OPCODE_SW: supported_o = 1'b1;
         default:                         supported_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream to instruction-memory loader: big-endian word assembly, halt/overflow/timeout
// termination. Define LOADER_OPCODE_CHECK_EN to reject opcodes the decoder does not implement.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = 8,
   parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [1:0]        o_err_code,
   output logic [ADDR_W:0]   o_word_count
);

   localparam int unsigned       TmoW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0]   TmoLimit = TmoW'(TIMEOUT_CYCLES);
   localparam logic [ADDR_W-1:0] AddrMax  = '1;

   ldr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       shift_q, shift_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic [1:0]        err_q, err_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [31:0] rx_word;
   logic        last_byte;
   logic        tmo_hit;
   logic        op_bad;

   assign rx_word   = {shift_q[23:0], i_rx_data};
   assign last_byte = (state_q == LDR_ST_LOAD) && i_rx_valid && (byte_cnt_q == 2'd3);
   // A byte in the would-be timeout cycle wins, so only idle cycles can hit the limit.
   assign tmo_hit   = (state_q == LDR_ST_LOAD) && !i_rx_valid && (byte_cnt_q != 2'd0) &&
                      ((tmo_q + TmoW'(1)) == TmoLimit);

`ifdef LOADER_OPCODE_CHECK_EN
   logic op_supported;

   instr_loader_opcheck u_opcheck (
      .opcode_i    (rx_word[31:26]),
      .supported_o (op_supported)
   );

   assign op_bad = (rx_word != HALT_WORD) && !op_supported;
`else
   assign op_bad = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= LDR_ST_IDLE;
         addr_q     <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         tmo_q      <= '0;
         wcnt_q     <= '0;
         err_q      <= LDR_ERR_NONE;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         tmo_q      <= tmo_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LDR_ST_IDLE, LDR_ST_DONE, LDR_ST_ERROR: begin
            if (i_start) state_d = LDR_ST_LOAD;
         end
         LDR_ST_LOAD: begin
            if (last_byte)    state_d = op_bad ? LDR_ST_ERROR : LDR_ST_WRITE;
            else if (tmo_hit) state_d = LDR_ST_ERROR;
         end
         LDR_ST_WRITE: begin
            if (wdata_q == HALT_WORD)  state_d = LDR_ST_DONE;
            else if (addr_q == AddrMax) state_d = LDR_ST_ERROR;
            else                        state_d = LDR_ST_LOAD;
         end
         default: state_d = LDR_ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d     = addr_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tmo_d      = tmo_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      unique case (state_q)
         LDR_ST_IDLE, LDR_ST_DONE, LDR_ST_ERROR: begin
            if (i_start) begin
               addr_d     = '0;
               byte_cnt_d = '0;
               shift_d    = '0;
               tmo_d      = '0;
               wcnt_d     = '0;
               err_d      = LDR_ERR_NONE;
            end
         end
         LDR_ST_LOAD: begin
            if (i_rx_valid) begin
               shift_d    = rx_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               tmo_d      = '0;
               if (byte_cnt_q == 2'd3) begin
                  waddr_d = addr_q;
                  if (op_bad) err_d   = LDR_ERR_BAD_OP;
                  else        wdata_d = rx_word;
               end
            end else if (byte_cnt_q != 2'd0) begin
               tmo_d = tmo_q + TmoW'(1);
               if (tmo_hit) err_d = LDR_ERR_TIMEOUT;
            end
         end
         LDR_ST_WRITE: begin
            addr_d = addr_q + ADDR_W'(1);
            wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
            if ((wdata_q != HALT_WORD) && (addr_q == AddrMax)) err_d = LDR_ERR_OVERFLOW;
            // Reception overlaps the write: this byte starts the next word.
            if (i_rx_valid) begin
               shift_d    = rx_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               tmo_d      = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      o_imem_we    = (state_q == LDR_ST_WRITE);
      o_busy       = (state_q == LDR_ST_LOAD) || (state_q == LDR_ST_WRITE);
      o_done       = (state_q == LDR_ST_DONE);
      o_error      = (state_q == LDR_ST_ERROR);
      o_err_code   = err_q;
      o_word_count = wcnt_q;
      o_imem_addr  = waddr_q;
      o_imem_wdata = wdata_q;
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized and directed bench for instr_loader against a byte-stream reference model.
module tb_instr_loader;

   localparam int unsigned AW   = 3;
   localparam int unsigned TMO  = 16;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic [AW:0]   word_count;

   int tests_run    = 0;
   int tests_failed = 0;

   instr_loader #(
      .ADDR_W         (AW),
      .HALT_WORD      (HALT),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .o_imem_we    (we),
      .o_imem_addr  (waddr),
      .o_imem_wdata (wdata),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error),
      .o_err_code   (err_code),
      .o_word_count (word_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] mon_addr[$];
   logic [31:0]   mon_data[$];
   int unsigned   mon_cyc[$];

   always @(negedge clk) begin
      if (!rst && we) begin
         mon_addr.push_back(waddr);
         mon_data.push_back(wdata);
         mon_cyc.push_back(cyc);
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit opcode_bad(input logic [31:0] w);
`ifdef LOADER_OPCODE_CHECK_EN
      int op;
      op = int'(w[31:26]);
      return (w != HALT) &&
             !(op inside {0, 2, 3, 4, 5, [8:15], 32, 33, 35, 36, 37, 39, 40, 41, 43});
`else
      return (w == HALT) && (w != HALT);
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".we"},    64'(we), 64'd0);
      check_val({tag, ".addr"},  64'(waddr), 64'd0);
      check_val({tag, ".wdata"}, 64'(wdata), 64'd0);
      check_val({tag, ".busy"},  64'(busy), 64'd0);
      check_val({tag, ".done"},  64'(done), 64'd0);
      check_val({tag, ".error"}, 64'(error), 64'd0);
      check_val({tag, ".code"},  64'(err_code), 64'd0);
      check_val({tag, ".count"}, 64'(word_count), 64'd0);
   endtask

   task automatic words_to_bytes(input logic [31:0] ws[$], output logic [7:0] bs[$],
                                 output int unsigned gs[$]);
      bs = {};
      gs = {};
      foreach (ws[i]) begin
         for (int k = 3; k >= 0; k--) begin
            bs.push_back(ws[i][k*8 +: 8]);
            gs.push_back(0);
         end
      end
   endtask

   // Drive one session, then compare against the model of the byte stream.
   task automatic run_session(input string name, input logic [7:0] bytes_in[$],
                              input int unsigned gaps_in[$], input int unsigned tail);
      int unsigned bcyc[$];
      logic [31:0] w;
      int unsigned nb, addr, cnt, ek, eaddr;
      logic [1:0]  ecode;
      int unsigned ea[$];
      logic [31:0] ed[$];
      int unsigned ec[$];

      mon_addr = {};
      mon_data = {};
      mon_cyc  = {};
      start    = 1'b1;
      tick();
      start    = 1'b0;
      foreach (bytes_in[i]) begin
         rx_valid = 1'b0;
         repeat (gaps_in[i]) tick();
         rx_data  = bytes_in[i];
         rx_valid = 1'b1;
         bcyc.push_back(cyc);
         tick();
      end
      rx_valid = 1'b0;
      repeat (tail) tick();

      // ek: 0 still loading, 1 done, 2 error
      w = '0; nb = 0; addr = 0; cnt = 0; ek = 0; eaddr = 0; ecode = 2'd0;
      for (int i = 0; i < bytes_in.size(); i++) begin
         if (nb != 0 && gaps_in[i] >= TMO) begin
            ek = 2; ecode = 2'd1;
            break;
         end
         w  = {w[23:0], bytes_in[i]};
         nb = nb + 1;
         if (nb == 4) begin
            nb = 0;
            if (opcode_bad(w)) begin
               ek = 2; ecode = 2'd3; eaddr = addr;
               break;
            end
            ea.push_back(addr);
            ed.push_back(w);
            ec.push_back(bcyc[i] + 1);
            cnt = cnt + 1;
            if (w == HALT) begin
               ek = 1;
               break;
            end
            if (addr == (1 << AW) - 1) begin
               ek = 2; ecode = 2'd2;
               break;
            end
            addr = addr + 1;
         end
      end
      if (ek == 0 && nb != 0 && tail >= TMO) begin
         ek = 2; ecode = 2'd1;
      end

      check_val({name, ".nwrites"}, 64'(mon_addr.size()), 64'(ea.size()));
      for (int i = 0; i < ea.size() && i < mon_addr.size(); i++) begin
         check_val($sformatf("%s.waddr%0d", name, i), 64'(mon_addr[i]), 64'(ea[i]));
         check_val($sformatf("%s.wdata%0d", name, i), 64'(mon_data[i]), 64'(ed[i]));
         check_val($sformatf("%s.wcyc%0d", name, i), 64'(mon_cyc[i]), 64'(ec[i]));
      end
      check_val({name, ".done"},  64'(done), 64'(ek == 1));
      check_val({name, ".error"}, 64'(error), 64'(ek == 2));
      check_val({name, ".busy"},  64'(busy), 64'(ek == 0));
      check_val({name, ".code"},  64'(err_code), 64'(ecode));
      check_val({name, ".count"}, 64'(word_count), 64'(cnt));
      if (ecode == 2'd3) begin
         check_val({name, ".badaddr"}, 64'(waddr), 64'(eaddr));
      end else if (ea.size() > 0) begin
         check_val({name, ".holdaddr"}, 64'(waddr), 64'(ea[ea.size()-1]));
         check_val({name, ".holddata"}, 64'(wdata), 64'(ed[ed.size()-1]));
      end
      if (ek == 0) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         tick();
      end
   endtask

   initial begin
      logic [31:0] ws[$];
      logic [7:0]  bs[$];
      int unsigned gs[$];
      int unsigned nw, r;

      rst      = 1'b1;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      ws = {32'h2008_0005, HALT};
      words_to_bytes(ws, bs, gs);
      run_session("basic", bs, gs, 4);
      check_val("basic.count_const", 64'(word_count), 64'd2);

      ws = {32'h8C01_0004, 32'h0022_1820, 32'hAC03_0008, HALT};
      words_to_bytes(ws, bs, gs);
      run_session("b2b", bs, gs, 4);

      bs = {8'h12, 8'h34};
      gs = {0, 0};
      run_session("timeout", bs, gs, TMO);
      check_val("timeout.code_const", 64'(err_code), 64'd1);

      ws = {32'h2008_0005, HALT};
      words_to_bytes(ws, bs, gs);
      gs[2] = TMO - 1;
      gs[5] = TMO - 1;
      gs[4] = 3 * TMO;
      run_session("bytewins", bs, gs, 4);

      ws = {};
      for (int i = 0; i < 8; i++) ws.push_back(32'h2008_0000 + 32'(i));
      ws.push_back(HALT);
      words_to_bytes(ws, bs, gs);
      run_session("overflow", bs, gs, 4);

      ws = {32'h2008_0005, 32'hFC00_0000, HALT};
      words_to_bytes(ws, bs, gs);
      run_session("badop", bs, gs, 4);

      start = 1'b1;
      tick();
      start    = 1'b0;
      rx_data  = 8'hAB;
      rx_valid = 1'b1;
      tick();
      tick();
      rx_valid = 1'b0;
      rst = 1'b1;
      #2;
      check_reset_outputs("midrst");
      tick();
      rst = 1'b0;
      tick();
      ws = {32'h2008_0005, HALT};
      words_to_bytes(ws, bs, gs);
      run_session("reload", bs, gs, 4);

      for (int s = 0; s < 40; s++) begin
         ws = {};
         nw = $urandom_range(1, 10);
         for (int i = 0; i < nw; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ws.push_back(HALT);
            else if (r < 5)  ws.push_back({6'd35, 26'($urandom)});
            else             ws.push_back($urandom);
         end
         ws.push_back(HALT);
         words_to_bytes(ws, bs, gs);
         foreach (gs[i]) begin
            r = $urandom_range(0, 11);
            if (r >= 6 && r <= 7)  gs[i] = $urandom_range(1, TMO - 1);
            else if (r == 8)       gs[i] = TMO - 1;
            else if (r == 9)       gs[i] = $urandom_range(TMO, 3 * TMO);
            else if (r == 10 && (i % 4) != 0) gs[i] = TMO + $urandom_range(0, 3);
            else                   gs[i] = 0;
            if ((i % 4) != 0 && gs[i] >= TMO && r == 9) gs[i] = 2;
         end
         run_session($sformatf("rand%0d", s), bs, gs, TMO + 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
